seven_seg_scan_mux: RTL

- Downstream stage of the Nexys4 display driver AXI4-Lite register bank.
- Takes the committed register contents: hex digit values, digit enables, decimal points and brightness.
- Time-multiplexes them onto the board's common-anode 8-digit seven-segment display.
- Provides inter-digit blanking against ghosting, 4-bit PWM brightness, and tear-free double-buffered updates applied only at frame boundaries.

---
 rtl/seven_seg_scan_mux.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed driver for a common-anode seven-segment display with inter-digit
// blanking, 4-bit PWM brightness and a pending/shadow image pair swapped at frame wrap.
module seven_seg_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              cur_digit,
    output logic                    frame_done
);

    // Wide enough to hold the slot count and to take a 4-bit PWM phase from its low bits.
    localparam int unsigned SLOT_W = ($clog2(SLOT_CYCLES) > 4) ? $clog2(SLOT_CYCLES) : 4;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic [SLOT_W-1:0]       slot_cnt;
    logic [2:0]              digit_q;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] pend_val, shad_val;
    logic [NUM_DIGITS-1:0]   pend_en, shad_en;
    logic [NUM_DIGITS-1:0]   pend_dp, shad_dp;
    logic [3:0]              pend_bright, shad_bright;
    logic                    boundary;
    logic                    slot_wrap;
    logic [SLOT_W-1:0]       slot_off;
    logic [3:0]              pwm_cnt;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    assign slot_wrap = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign boundary  = slot_wrap && (digit_q == 3'(NUM_DIGITS - 1));
    assign upd_ready = ~pending;
    assign cur_digit = digit_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_cnt   <= '0;
            digit_q    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (slot_wrap) begin
                slot_cnt <= '0;
                digit_q  <= (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // A boundary swap and a new capture never coincide: capture needs pending clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            pend_val    <= '0;
            pend_en     <= '0;
            pend_dp     <= '0;
            pend_bright <= '0;
            shad_val    <= '0;
            shad_en     <= '0;
            shad_dp     <= '0;
            shad_bright <= '0;
        end else if (boundary && pending) begin
            pending     <= 1'b0;
            shad_val    <= pend_val;
            shad_en     <= pend_en;
            shad_dp     <= pend_dp;
            shad_bright <= pend_bright;
        end else if (upd_valid && !pending) begin
            pending     <= 1'b1;
            pend_val    <= digit_val;
            pend_en     <= digit_en;
            pend_dp     <= dp_in;
            pend_bright <= bright;
        end
    end

    // PWM phase is the offset into the active window, so it reads 0 at the end of blanking.
    assign slot_off = slot_cnt - SLOT_W'(BLANK_CYCLES);
    assign pwm_cnt  = slot_off[3:0];

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        lit   = (slot_cnt >= SLOT_W'(BLANK_CYCLES)) && shad_en[digit_q]
                && (pwm_cnt <= shad_bright);
        if (lit) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_d = ~decode(shad_val[4*digit_q +: 4]);
            dp_d  = ~shad_dp[digit_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
